// File: rtl/lfm_out_reg.sv
// lfm_out_reg
// Output register at the far end of the LFM phase-accumulator interface.
// It takes part in the ready handshake with the accumulator and captures the
// sine-ROM samples addressed during one packet. Samples are packed LANES per
// DAC word, with lane 0 (the earliest sample) in the LSBs. A final partial
// word is filled out with PAD. At the end of each packet the number of
// captured samples is compared with the packet length that was latched.
//
// Ports
//   CLK             in   system clock, rising edge
//   RESET_N         in   asynchronous active-low reset
//   SIGN_START_CALC in   accumulator armed, requests handshake
//   SIGN_STOP_CALC  in   high in the cycle the last ROM address is driven
//   NUM_OF_SAMPLES  in   packet length, latched on START in IDLE
//   ROM_DATA        in   sine ROM output, valid ROM_LATENCY cycles after address
//   OUT_REG_READY   out  block can accept a new packet
//   DAC_DATA        out  packed word, held between strobes
//   DAC_VALID       out  one-cycle strobe per word
//   DAC_LAST        out  final word of a packet (with DAC_VALID)
//   PKT_DONE        out  one-cycle pulse with the final word
//   ERR_COUNT       out  sticky until next START: captured count != latched length
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready; START latches length and clears count/lane/error
// ARMED | ready; waits for the accumulator to drop START
// RUN   | one ROM address per cycle; STOP moves to DRAIN
// DRAIN | waits for in-flight samples, flushes last word, pulses done

module lfm_out_reg #(
   parameter int                DATA_W      = 12,
   parameter int                LANES       = 4,
   parameter int                ROM_LATENCY = 1,
   parameter logic [DATA_W-1:0] PAD         = '0
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      SIGN_START_CALC,
   input  logic                      SIGN_STOP_CALC,
   input  logic [31:0]               NUM_OF_SAMPLES,
   input  logic [DATA_W-1:0]         ROM_DATA,
   output logic                      OUT_REG_READY,
   output logic [LANES*DATA_W-1:0]   DAC_DATA,
   output logic                      DAC_VALID,
   output logic                      DAC_LAST,
   output logic                      PKT_DONE,
   output logic                      ERR_COUNT
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DW = $clog2(ROM_LATENCY + 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(LANES - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(ROM_LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DW-1:0]           r_drain_cnt;
   logic [ROM_LATENCY-1:0]  r_vpipe;
   logic [DATA_W-1:0]       r_lane [LANES];
   logic [DATA_W-1:0]       w_lane_nxt [LANES];
   logic [IW-1:0]           r_idx;
   logic [IW:0]             w_fill;
   logic [31:0]             r_cnt;
   logic [31:0]             r_num;
   logic [31:0]             w_cnt_nxt;
   logic [LANES*DATA_W-1:0] w_word;
   logic                    w_addr_valid;
   logic                    w_smp_valid;
   logic                    w_flush;
   logic                    w_full;
   logic                    w_partial;
   logic                    w_start_pkt;

   // ---------------- FSM ----------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_valid = 1'b0;
      case (r_state)
         S_IDLE:  if (SIGN_START_CALC) w_state_nxt = S_ARMED;
         S_ARMED: if (!SIGN_START_CALC) w_state_nxt = S_RUN;
         S_RUN: begin
            w_addr_valid = 1'b1;
            if (SIGN_STOP_CALC) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (r_drain_cnt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign OUT_REG_READY = (r_state == S_IDLE) || (r_state == S_ARMED);
   assign w_start_pkt   = (r_state == S_IDLE) && SIGN_START_CALC;

   // DRAIN lasts ROM_LATENCY+1 cycles: the last sample lands when the count
   // reaches 1 (flush edge), and the final cycle carries the DAC_LAST word
   // with READY still low.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_drain_cnt <= '0;
      end else if (r_state == S_RUN && SIGN_STOP_CALC) begin
         r_drain_cnt <= DRAIN_LOAD;
      end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
         r_drain_cnt <= r_drain_cnt - DW'(1);
      end
   end

   assign w_flush = (r_state == S_DRAIN) && (r_drain_cnt == DW'(1));

   // ---------------- address-valid pipeline ----------------
   generate
      if (ROM_LATENCY == 1) begin : g_pipe1
         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) r_vpipe <= '0;
            else          r_vpipe <= w_addr_valid;
         end
      end else begin : g_pipen
         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) r_vpipe <= '0;
            else          r_vpipe <= {r_vpipe[ROM_LATENCY-2:0], w_addr_valid};
         end
      end
   endgenerate

   assign w_smp_valid = r_vpipe[ROM_LATENCY-1];

   // ---------------- packing ----------------
   // The word is built from the lane contents including this cycle's capture.
   // Lanes at or above the fill level take PAD, so stale lanes never leak.
   always_comb begin
      for (int i = 0; i < LANES; i++) w_lane_nxt[i] = r_lane[i];
      if (w_smp_valid) w_lane_nxt[r_idx] = ROM_DATA;
      w_fill = {1'b0, r_idx} + {{IW{1'b0}}, w_smp_valid};
      w_word = '0;
      for (int i = 0; i < LANES; i++) begin
         w_word[i*DATA_W +: DATA_W] = (i < int'(w_fill)) ? w_lane_nxt[i] : PAD;
      end
   end

   assign w_full    = w_smp_valid && (r_idx == IDX_LAST);
   assign w_partial = w_flush && !w_full && (w_fill != '0);
   assign w_cnt_nxt = r_cnt + (w_smp_valid ? 32'd1 : 32'd0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_num     <= '0;
         DAC_DATA  <= '0;
         DAC_VALID <= 1'b0;
         DAC_LAST  <= 1'b0;
         PKT_DONE  <= 1'b0;
         ERR_COUNT <= 1'b0;
      end else begin
         DAC_VALID <= 1'b0;
         DAC_LAST  <= 1'b0;
         PKT_DONE  <= w_flush;
         if (w_start_pkt) begin
            r_num     <= NUM_OF_SAMPLES;
            r_cnt     <= '0;
            r_idx     <= '0;
            ERR_COUNT <= 1'b0;
         end else begin
            if (w_smp_valid) begin
               for (int i = 0; i < LANES; i++) r_lane[i] <= w_lane_nxt[i];
               r_cnt <= w_cnt_nxt;
               if (r_num == 32'd0) ERR_COUNT <= 1'b1;
            end
            if (w_full || w_partial) begin
               DAC_DATA  <= w_word;
               DAC_VALID <= 1'b1;
               DAC_LAST  <= w_flush;
               r_idx     <= '0;
            end else if (w_smp_valid) begin
               r_idx <= r_idx + IW'(1);
            end
            if (w_flush) ERR_COUNT <= (w_cnt_nxt != r_num);
         end
      end
   end

endmodule

// File: tb/tb_lfm_out_reg.sv
module tb_lfm_out_reg;

   localparam int DW = 12;
   localparam int WW = 48;

   typedef struct packed {
      logic [WW-1:0] d;
      logic          l;
      logic          p;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          start [2];
   logic          stop  [2];
   logic [31:0]   num_i [2];
   logic [DW-1:0] rom   [2];
   logic [DW-1:0] av    [2];
   logic          ready [2];
   logic          valid [2];
   logic          last  [2];
   logic          done  [2];
   logic          err   [2];
   logic [WW-1:0] dac   [2];
   logic [DW-1:0] rp0;
   logic [DW-1:0] rp1   [3];

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc [2];
   int   stop_cyc = 0;

   always #5 CLK = ~CLK;

   lfm_out_reg #(.DATA_W(DW), .LANES(4), .ROM_LATENCY(1), .PAD(12'h000)) u_dut0 (
      .CLK(CLK), .RESET_N(RESET_N),
      .SIGN_START_CALC(start[0]), .SIGN_STOP_CALC(stop[0]),
      .NUM_OF_SAMPLES(num_i[0]), .ROM_DATA(rom[0]),
      .OUT_REG_READY(ready[0]), .DAC_DATA(dac[0]), .DAC_VALID(valid[0]),
      .DAC_LAST(last[0]), .PKT_DONE(done[0]), .ERR_COUNT(err[0])
   );

   lfm_out_reg #(.DATA_W(DW), .LANES(4), .ROM_LATENCY(3), .PAD(12'h000)) u_dut1 (
      .CLK(CLK), .RESET_N(RESET_N),
      .SIGN_START_CALC(start[1]), .SIGN_STOP_CALC(stop[1]),
      .NUM_OF_SAMPLES(num_i[1]), .ROM_DATA(rom[1]),
      .OUT_REG_READY(ready[1]), .DAC_DATA(dac[1]), .DAC_VALID(valid[1]),
      .DAC_LAST(last[1]), .PKT_DONE(done[1]), .ERR_COUNT(err[1])
   );

   // ROM models: latency 1 for instance 0, latency 3 for instance 1
   always @(posedge CLK) begin
      cyc    <= cyc + 1;
      rp0    <= av[0];
      rp1[0] <= av[1];
      rp1[1] <= rp1[0];
      rp1[2] <= rp1[1];
   end
   assign rom[0] = rp0;
   assign rom[1] = rp1[2];

   // monitor / scoreboard
   always @(negedge CLK) begin
      exp_t got;
      exp_t e;
      for (int s = 0; s < 2; s++) begin
         if (RESET_N && (valid[s] || done[s])) begin
            got = {dac[s], last[s], done[s]};
            checks++;
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
               errors++;
               $display("FAIL unexpected_word inst%0d: got %h, expected no word", s, got);
            end else begin
               if (s == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL word inst%0d: got %h expected %h", s, got, e);
               end
            end
            if (valid[s] && last[s]) last_cyc[s] = cyc;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic push(input int s, input logic [WW-1:0] d, input logic l);
      exp_t e;
      e = {d, l, l};
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic rst_chk(input string nm);
      chk(nm, {11'd0, ready[0], valid[0], last[0], done[0], err[0], dac[0]},
              {11'd0, 1'b1, 4'b0000, 48'd0});
   endtask

   // Acts as the accumulator: handshake, n address cycles, STOP on the last.
   // rst_at >= 0: reset in that address cycle; rst_at == -2: reset in the done cycle.
   task automatic run_pkt(input int s, input logic [31:0] num, input int n,
                          input logic [DW-1:0] base, input logic exp_err,
                          input int rst_at, input bit start_on_stop, output int waited);
      int g;
      int rdy_bad;
      g = 0;
      @(negedge CLK);
      while (!ready[s] && g < 50) begin
         @(negedge CLK);
         g++;
      end
      waited = g;
      if (!ready[s]) begin
         chk("wait_ready_timeout", 64'(ready[s]), 64'd1);
         return;
      end
      start[s] = 1'b1;
      num_i[s] = num;
      @(negedge CLK);
      start[s] = 1'b0;
      num_i[s] = 32'hDEAD_BEEF;
      @(negedge CLK);
      rdy_bad = 0;
      for (int k = 0; k < n; k++) begin
         if (k == rst_at) begin
            #1 RESET_N = 1'b0;
            #1 rst_chk("reset_mid_run");
            stop[s]  = 1'b0;
            start[s] = 1'b0;
            return;
         end
         av[s]   = base + DW'(k);
         stop[s] = (k == n - 1);
         if (k == n - 1) begin
            stop_cyc = cyc;
            start[s] = start_on_stop;
         end
         if (ready[s]) rdy_bad++;
         @(negedge CLK);
      end
      stop[s]  = 1'b0;
      start[s] = 1'b0;
      g = 0;
      while (!done[s] && g < 20) begin
         if (ready[s]) rdy_bad++;
         @(negedge CLK);
         g++;
      end
      chk("pkt_done_seen", 64'(done[s]), 64'd1);
      if (ready[s]) rdy_bad++;
      chk("ready_low_run_to_done", 64'(rdy_bad), 64'd0);
      chk("err_count", 64'(err[s]), 64'(exp_err));
      if (rst_at == -2) begin
         #2 RESET_N = 1'b0;
         #1 rst_chk("reset_at_done");
      end
   endtask

   initial begin
      int w;
      int g;
      for (int s = 0; s < 2; s++) begin
         start[s] = 1'b0;
         stop[s]  = 1'b0;
         num_i[s] = 32'd0;
         av[s]    = '0;
         last_cyc[s] = 0;
      end
      repeat (3) @(negedge CLK);
      rst_chk("reset_state");
      chk("reset_ready_inst1", 64'(ready[1]), 64'd1);
      RESET_N = 1'b1;
      @(negedge CLK);

      // STOP while idle is ignored
      stop[0] = 1'b1;
      @(negedge CLK);
      stop[0] = 1'b0;
      @(negedge CLK);
      chk("stop_in_idle_ready", 64'(ready[0]), 64'd1);

      // NUM=8, samples 1..8
      push(0, 48'h004003002001, 1'b0);
      push(0, 48'h008007006005, 1'b1);
      run_pkt(0, 32'd8, 8, 12'h001, 1'b0, -1, 1'b0, w);

      // NUM=6, partial final word; START together with STOP (STOP wins)
      push(0, 48'h004003002001, 1'b0);
      push(0, 48'h000000006005, 1'b1);
      run_pkt(0, 32'd6, 6, 12'h001, 1'b0, -1, 1'b1, w);

      // NUM=8 latched but only 7 addresses
      push(0, 48'h004003002001, 1'b0);
      push(0, 48'h000007006005, 1'b1);
      run_pkt(0, 32'd8, 7, 12'h001, 1'b1, -1, 1'b0, w);

      // reset while the final word and error are being presented
      push(0, 48'h000000042041, 1'b1);
      run_pkt(0, 32'd3, 2, 12'h041, 1'b1, -2, 1'b0, w);
      @(negedge CLK);
      RESET_N = 1'b1;

      // reset in the middle of RUN: partial packet dropped, no word
      run_pkt(0, 32'd8, 8, 12'h051, 1'b0, 2, 1'b0, w);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (4) @(negedge CLK);

      // back-to-back packets NUM=5 then NUM=3
      push(0, 48'h024023022021, 1'b0);
      push(0, 48'h000000000025, 1'b1);
      run_pkt(0, 32'd5, 5, 12'h021, 1'b0, -1, 1'b0, w);
      push(0, 48'h000033032031, 1'b1);
      run_pkt(0, 32'd3, 3, 12'h031, 1'b0, -1, 1'b0, w);
      chk("b2b_start_wait", 64'(w), 64'd0);

      // ROM_LATENCY=3 instance, NUM=4
      push(1, 48'h014013012011, 1'b1);
      run_pkt(1, 32'd4, 4, 12'h011, 1'b0, -1, 1'b0, w);
      @(negedge CLK);
      chk("lat3_stop_to_last", 64'(last_cyc[1] - stop_cyc), 64'd4);
      chk("ready_after_done", 64'(ready[1]), 64'd1);

      g = 0;
      while ((q0.size() + q1.size()) != 0 && g < 20) begin
         @(negedge CLK);
         g++;
      end
      chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
